// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle ARM control unit.
// Holds the FSM state type, datapath select encodings and the condition evaluator.
package mc_ctrl_pkg;

   typedef enum logic [3:0] {
      FETCH,
      DECODE,
      MEMADR,
      MEMREAD,
      MEMWB,
      MEMWRITE,
      EXECUTER,
      EXECUTEI,
      ALUWB,
      BRANCH
   } state_t;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;
   localparam logic [1:0] ALU_ORR = 2'b11;

   localparam logic [3:0] CMD_AND = 4'b0000;
   localparam logic [3:0] CMD_SUB = 4'b0010;
   localparam logic [3:0] CMD_ADD = 4'b0100;
   localparam logic [3:0] CMD_CMP = 4'b1010;
   localparam logic [3:0] CMD_ORR = 4'b1100;

   localparam logic [1:0] OP_DP  = 2'b00;
   localparam logic [1:0] OP_MEM = 2'b01;
   localparam logic [1:0] OP_BR  = 2'b10;

   localparam logic [3:0] COND_EQ = 4'b0000;
   localparam logic [3:0] COND_NE = 4'b0001;
   localparam logic [3:0] COND_CS = 4'b0010;
   localparam logic [3:0] COND_CC = 4'b0011;
   localparam logic [3:0] COND_MI = 4'b0100;
   localparam logic [3:0] COND_PL = 4'b0101;
   localparam logic [3:0] COND_VS = 4'b0110;
   localparam logic [3:0] COND_VC = 4'b0111;
   localparam logic [3:0] COND_HI = 4'b1000;
   localparam logic [3:0] COND_LS = 4'b1001;
   localparam logic [3:0] COND_GE = 4'b1010;
   localparam logic [3:0] COND_LT = 4'b1011;
   localparam logic [3:0] COND_GT = 4'b1100;
   localparam logic [3:0] COND_LE = 4'b1101;
   localparam logic [3:0] COND_AL = 4'b1110;

   localparam logic [1:0] SRCA_REG   = 2'b00;
   localparam logic [1:0] SRCA_PC    = 2'b01;
   localparam logic [1:0] SRCB_REG   = 2'b00;
   localparam logic [1:0] SRCB_IMM   = 2'b01;
   localparam logic [1:0] SRCB_FOUR  = 2'b10;
   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_DATA   = 2'b01;
   localparam logic [1:0] RES_ALU    = 2'b10;

   // flags are packed {N,Z,C,V}; cond 1111 is never taken
   function automatic logic cond_holds(input logic [3:0] cond, input logic [3:0] flags);
      logic n;
      logic z;
      logic c;
      logic v;
      logic result;
      {n, z, c, v} = flags;
      case (cond)
         COND_EQ: result = z;
         COND_NE: result = ~z;
         COND_CS: result = c;
         COND_CC: result = ~c;
         COND_MI: result = n;
         COND_PL: result = ~n;
         COND_VS: result = v;
         COND_VC: result = ~v;
         COND_HI: result = c & ~z;
         COND_LS: result = ~c | z;
         COND_GE: result = (n == v);
         COND_LT: result = (n != v);
         COND_GT: result = ~z & (n == v);
         COND_LE: result = z | (n != v);
         COND_AL: result = 1'b1;
         default: result = 1'b0;
      endcase
      return result;
   endfunction

endpackage

// File: rtl/mc_controller_if.sv
// Control/status bundle between the multicycle controller and its datapath.
// The controller side takes the master modport, the datapath the slave modport.
interface mc_controller_if;

   logic [31:0] Instr;
   logic [3:0]  ALUFlags;
   logic        PCWrite;
   logic        MemWrite;
   logic        RegWrite;
   logic        IRWrite;
   logic        AdrSrc;
   logic [1:0]  RegSrc;
   logic [1:0]  ALUSrcA;
   logic [1:0]  ALUSrcB;
   logic [1:0]  ResultSrc;
   logic [1:0]  ImmSrc;
   logic [1:0]  ALUControl;

   modport master (
      input  Instr, ALUFlags,
      output PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc,
             ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl
   );

   modport slave (
      output Instr, ALUFlags,
      input  PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc,
             ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl
   );

endinterface

// File: rtl/mc_main_fsm.sv
// Main sequencer: state register, next-state logic and Moore output decode.
// Architectural write enables are qualified by the captured condition and by reset.
module mc_main_fsm
   import mc_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] op,
   input  logic       i_bit,
   input  logic       l_bit,
   input  logic       cmd_ok,
   input  logic       is_cmp,
   input  logic       cond_q,
   input  logic       rd_is_pc,
   input  logic [1:0] alu_op,
   output state_t     state,
   output logic       pc_write,
   output logic       mem_write,
   output logic       reg_write,
   output logic       ir_write,
   output logic       adr_src,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] result_src,
   output logic [1:0] alu_control
);

   state_t state_q;
   state_t state_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = FETCH;
      case (state_q)
         FETCH:    state_d = DECODE;
         DECODE: begin
            case (op)
               OP_DP:   state_d = !cmd_ok ? FETCH : (i_bit ? EXECUTEI : EXECUTER);
               OP_MEM:  state_d = MEMADR;
               OP_BR:   state_d = BRANCH;
               default: state_d = FETCH;
            endcase
         end
         EXECUTER: state_d = is_cmp ? FETCH : ALUWB;
         EXECUTEI: state_d = is_cmp ? FETCH : ALUWB;
         MEMADR:   state_d = l_bit ? MEMREAD : MEMWRITE;
         MEMREAD:  state_d = MEMWB;
         default:  state_d = FETCH;
      endcase
   end

   always_comb begin
      pc_write    = 1'b0;
      mem_write   = 1'b0;
      reg_write   = 1'b0;
      ir_write    = 1'b0;
      adr_src     = 1'b0;
      alu_src_a   = SRCA_REG;
      alu_src_b   = SRCB_REG;
      result_src  = RES_ALUOUT;
      alu_control = ALU_ADD;
      case (state_q)
         FETCH: begin
            ir_write   = 1'b1;
            pc_write   = 1'b1;
            alu_src_a  = SRCA_PC;
            alu_src_b  = SRCB_FOUR;
            result_src = RES_ALU;
         end
         DECODE: begin
            alu_src_a  = SRCA_PC;
            alu_src_b  = SRCB_FOUR;
            result_src = RES_ALU;
         end
         EXECUTER: begin
            alu_control = alu_op;
         end
         EXECUTEI: begin
            alu_src_b   = SRCB_IMM;
            alu_control = alu_op;
         end
         ALUWB: begin
            reg_write = cond_q;
            pc_write  = cond_q & rd_is_pc;
         end
         MEMADR: begin
            alu_src_b = SRCB_IMM;
         end
         MEMREAD: begin
            adr_src = 1'b1;
         end
         MEMWB: begin
            result_src = RES_DATA;
            reg_write  = cond_q;
            pc_write   = cond_q & rd_is_pc;
         end
         MEMWRITE: begin
            adr_src   = 1'b1;
            mem_write = cond_q;
         end
         BRANCH: begin
            alu_src_b  = SRCB_IMM;
            result_src = RES_ALU;
            pc_write   = cond_q;
         end
         default: begin
            alu_control = ALU_ADD;
         end
      endcase
      // the state register only settles at the next edge, so suppress writes for the whole reset cycle
      if (reset) begin
         pc_write  = 1'b0;
         mem_write = 1'b0;
         reg_write = 1'b0;
         ir_write  = 1'b0;
      end
   end

   assign state = state_q;

endmodule

// File: rtl/mc_controller.sv
// Multicycle ARM control unit: instruction decode, NZCV flags, condition gating.
// Sequencing and per-state select outputs live in mc_main_fsm.
module mc_controller
   import mc_ctrl_pkg::*;
(
   input  logic           clk,
   input  logic           reset,
   mc_controller_if.master bus
);

   logic [1:0] op;
   logic       i_bit;
   logic [3:0] cmd;
   logic       s_bit;
   logic       l_bit;
   logic       rd_is_pc;
   logic       cmd_ok;
   logic       is_cmp;
   logic       alu_sets_cv;
   logic [1:0] alu_op;
   logic       unused_instr;

   state_t     state;
   logic       flags_update;
   logic [3:0] flags_q;
   logic [3:0] flags_d;
   logic       cond_q;
   logic       cond_d;

   logic       pc_write;
   logic       mem_write;
   logic       reg_write;
   logic       ir_write;
   logic       adr_src;
   logic [1:0] alu_src_a;
   logic [1:0] alu_src_b;
   logic [1:0] result_src;
   logic [1:0] alu_control;

   assign op           = bus.Instr[27:26];
   assign i_bit        = bus.Instr[25];
   assign cmd          = bus.Instr[24:21];
   assign s_bit        = bus.Instr[20];
   assign l_bit        = bus.Instr[20];
   assign rd_is_pc     = (bus.Instr[15:12] == 4'hF);
   assign unused_instr = ^{bus.Instr[19:16], bus.Instr[11:0]};

   always_comb begin
      cmd_ok      = 1'b1;
      is_cmp      = 1'b0;
      alu_sets_cv = 1'b1;
      alu_op      = ALU_ADD;
      case (cmd)
         CMD_ADD: alu_op = ALU_ADD;
         CMD_SUB: alu_op = ALU_SUB;
         CMD_AND: begin
            alu_op      = ALU_AND;
            alu_sets_cv = 1'b0;
         end
         CMD_ORR: begin
            alu_op      = ALU_ORR;
            alu_sets_cv = 1'b0;
         end
         CMD_CMP: begin
            alu_op = ALU_SUB;
            is_cmp = 1'b1;
         end
         default: begin
            cmd_ok      = 1'b0;
            alu_sets_cv = 1'b0;
         end
      endcase
   end

   // logical ops leave carry and overflow as they were
   assign flags_update = ((state == EXECUTER) || (state == EXECUTEI)) && cond_q && (s_bit || is_cmp);

   always_comb begin
      flags_d = flags_q;
      if (flags_update) begin
         flags_d[3:2] = bus.ALUFlags[3:2];
         if (alu_sets_cv) begin
            flags_d[1:0] = bus.ALUFlags[1:0];
         end
      end
   end

   // condition is frozen in DECODE so later writes never see flags from this instruction's ALU
   always_comb begin
      cond_d = cond_q;
      if (state == DECODE) begin
         cond_d = cond_holds(bus.Instr[31:28], flags_q);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         flags_q <= 4'b0000;
         cond_q  <= 1'b0;
      end else begin
         flags_q <= flags_d;
         cond_q  <= cond_d;
      end
   end

   mc_main_fsm u_main_fsm (
      .clk         (clk),
      .reset       (reset),
      .op          (op),
      .i_bit       (i_bit),
      .l_bit       (l_bit),
      .cmd_ok      (cmd_ok),
      .is_cmp      (is_cmp),
      .cond_q      (cond_q),
      .rd_is_pc    (rd_is_pc),
      .alu_op      (alu_op),
      .state       (state),
      .pc_write    (pc_write),
      .mem_write   (mem_write),
      .reg_write   (reg_write),
      .ir_write    (ir_write),
      .adr_src     (adr_src),
      .alu_src_a   (alu_src_a),
      .alu_src_b   (alu_src_b),
      .result_src  (result_src),
      .alu_control (alu_control)
   );

   assign bus.PCWrite    = pc_write;
   assign bus.MemWrite   = mem_write;
   assign bus.RegWrite   = reg_write;
   assign bus.IRWrite    = ir_write;
   assign bus.AdrSrc     = adr_src;
   assign bus.ALUSrcA    = alu_src_a;
   assign bus.ALUSrcB    = alu_src_b;
   assign bus.ResultSrc  = result_src;
   assign bus.ALUControl = alu_control;
   assign bus.ImmSrc     = op;
   assign bus.RegSrc     = {(op == OP_MEM) && !l_bit, (op == OP_BR)};

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: directed instruction scenarios followed by a
// random instruction stream, all checked cycle by cycle against an instruction-level model.
module tb_mc_controller;

   logic clk;
   logic reset;
   int   total;
   int   bad;

   logic [3:0]  m_flags;
   logic [16:0] exp_q[$];

   mc_controller_if bus ();

   mc_controller dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "[TB] time limit exceeded");
   end

   function automatic logic cond_ok(input logic [3:0] cond, input logic [3:0] f);
      logic n;
      logic z;
      logic c;
      logic v;
      n = f[3];
      z = f[2];
      c = f[1];
      v = f[0];
      case (cond)
         4'd0:    return z;
         4'd1:    return !z;
         4'd2:    return c;
         4'd3:    return !c;
         4'd4:    return n;
         4'd5:    return !n;
         4'd6:    return v;
         4'd7:    return !v;
         4'd8:    return c && !z;
         4'd9:    return !c || z;
         4'd10:   return n == v;
         4'd11:   return n != v;
         4'd12:   return !z && (n == v);
         4'd13:   return z || (n != v);
         4'd14:   return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   // packed as {PCWrite,MemWrite,RegWrite,IRWrite,AdrSrc,RegSrc,ALUSrcA,ALUSrcB,ResultSrc,ImmSrc,ALUControl}
   function automatic logic [16:0] mk(input logic [31:0] instr, input logic pcw, input logic memw,
                                      input logic regw, input logic irw, input logic adr,
                                      input logic [1:0] srca, input logic [1:0] srcb,
                                      input logic [1:0] res, input logic [1:0] alu);
      logic [1:0] op;
      logic [1:0] regsrc;
      op     = instr[27:26];
      regsrc = {(op == 2'b01) && !instr[20], op == 2'b10};
      return {pcw, memw, regw, irw, adr, regsrc, srca, srcb, res, op, alu};
   endfunction

   function automatic logic [16:0] observed();
      return {bus.PCWrite, bus.MemWrite, bus.RegWrite, bus.IRWrite, bus.AdrSrc, bus.RegSrc,
              bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc, bus.ImmSrc, bus.ALUControl};
   endfunction

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic apply_stimulus(input logic [31:0] instr, input logic [3:0] af);
      bus.Instr    = instr;
      bus.ALUFlags = af;
      #1;
   endtask

   // expected per-cycle outputs of one instruction, updating the model flags as a side effect
   task automatic build_expected(input logic [31:0] instr, input logic [3:0] af);
      logic       c;
      logic [1:0] op;
      logic       rd15;
      logic       known;
      logic       cmp;
      logic       cv;
      logic [1:0] alu;
      exp_q.delete();
      op    = instr[27:26];
      rd15  = (instr[15:12] == 4'd15);
      c     = cond_ok(instr[31:28], m_flags);
      known = 1'b1;
      cmp   = 1'b0;
      cv    = 1'b1;
      alu   = 2'b00;
      exp_q.push_back(mk(instr, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 2'b10, 2'b10, 2'b00));
      exp_q.push_back(mk(instr, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b10, 2'b10, 2'b00));
      if (op == 2'b00) begin
         case (instr[24:21])
            4'b0100: alu = 2'b00;
            4'b0010: alu = 2'b01;
            4'b0000: begin alu = 2'b10; cv = 1'b0; end
            4'b1100: begin alu = 2'b11; cv = 1'b0; end
            4'b1010: begin alu = 2'b01; cmp = 1'b1; end
            default: known = 1'b0;
         endcase
         if (known) begin
            exp_q.push_back(mk(instr, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00,
                               instr[25] ? 2'b01 : 2'b00, 2'b00, alu));
            if (!cmp) begin
               exp_q.push_back(mk(instr, c && rd15, 1'b0, c, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00));
            end
            if (c && (instr[20] || cmp)) begin
               m_flags[3:2] = af[3:2];
               if (cv) m_flags[1:0] = af[1:0];
            end
         end
      end else if (op == 2'b01) begin
         exp_q.push_back(mk(instr, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 2'b00));
         if (instr[20]) begin
            exp_q.push_back(mk(instr, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00));
            exp_q.push_back(mk(instr, c && rd15, 1'b0, c, 1'b0, 1'b0, 2'b00, 2'b00, 2'b01, 2'b00));
         end else begin
            exp_q.push_back(mk(instr, 1'b0, c, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00));
         end
      end else if (op == 2'b10) begin
         exp_q.push_back(mk(instr, c, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 2'b00));
      end
   endtask

   // entered and left at posedge+1 with the DUT in FETCH
   task automatic run_instr(input string tag, input logic [31:0] instr, input logic [3:0] af);
      apply_stimulus(instr, af);
      build_expected(instr, af);
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i > 0) begin
            @(posedge clk);
            #1;
         end
         check_output($sformatf("%s cyc%0d", tag, i), {15'd0, observed()}, {15'd0, exp_q[i]});
      end
      @(posedge clk);
      #1;
      check_output($sformatf("%s flags", tag), {28'd0, dut.flags_q}, {28'd0, m_flags});
   endtask

   function automatic logic [31:0] random_instr();
      logic [31:0] ins;
      int          cls;
      ins        = $urandom();
      cls        = $urandom_range(0, 4);
      ins[31:28] = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) ins[15:12] = 4'hF;
      case (cls)
         0, 1: begin
            ins[27:26] = 2'b00;
            case ($urandom_range(0, 5))
               0: ins[24:21] = 4'b0100;
               1: ins[24:21] = 4'b0010;
               2: ins[24:21] = 4'b0000;
               3: ins[24:21] = 4'b1100;
               4: ins[24:21] = 4'b1010;
               default: ins[24:21] = 4'($urandom_range(0, 15));
            endcase
         end
         2: ins[27:26] = 2'b01;
         3: ins[27:26] = 2'b10;
         default: ins[27:26] = 2'b11;
      endcase
      return ins;
   endfunction

   initial begin
      logic [31:0] ins;
      logic [16:0] e;
      total        = 0;
      bad          = 0;
      m_flags      = 4'b0000;
      reset        = 1'b1;
      bus.Instr    = 32'h0;
      bus.ALUFlags = 4'h0;

      $display("[TB] reset held for two cycles");
      @(posedge clk);
      #1;
      check_output("reset0 enables", {28'd0, bus.PCWrite, bus.MemWrite, bus.RegWrite, bus.IRWrite}, 32'd0);
      @(posedge clk);
      #1;
      check_output("reset1 enables", {28'd0, bus.PCWrite, bus.MemWrite, bus.RegWrite, bus.IRWrite}, 32'd0);
      reset = 1'b0;
      #1;
      check_output("reset flags", {28'd0, dut.flags_q}, 32'd0);

      $display("[TB] directed instructions");
      run_instr("adds", 32'hE2921005, 4'b0000);
      run_instr("cmp_eq", 32'hE1510001, 4'b0110);
      run_instr("beq_taken", 32'h0A000002, 4'b0000);
      run_instr("cmp_ne", 32'hE1510001, 4'b0000);
      run_instr("beq_not", 32'h0A000002, 4'b0110);
      run_instr("ldr", 32'hE5903008, 4'b0000);
      run_instr("cmp_z", 32'hE1510001, 4'b0100);
      run_instr("strne", 32'h15803000, 4'b0000);
      run_instr("undef_op", 32'hEC000000, 4'b1111);
      run_instr("unsup_cmd", 32'hE0300000, 4'b1111);
      run_instr("addpc", 32'hE080F001, 4'b0000);

      $display("[TB] reset during MEMADR");
      ins = 32'hE5803000;
      apply_stimulus(ins, 4'b0000);
      e = mk(ins, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 2'b10, 2'b10, 2'b00);
      check_output("mid_rst fetch", {15'd0, observed()}, {15'd0, e});
      @(posedge clk);
      #1;
      e = mk(ins, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b10, 2'b10, 2'b00);
      check_output("mid_rst decode", {15'd0, observed()}, {15'd0, e});
      @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      check_output("mid_rst enables", {28'd0, bus.PCWrite, bus.MemWrite, bus.RegWrite, bus.IRWrite}, 32'd0);
      @(posedge clk);
      #1;
      reset   = 1'b0;
      m_flags = 4'b0000;
      #1;
      run_instr("after_rst", 32'hE5903008, 4'b0000);

      $display("[TB] random instruction stream");
      for (int k = 0; k < 150; k++) begin
         run_instr($sformatf("rnd%0d", k), random_instr(), 4'($urandom_range(0, 15)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
Control unit for the multicycle ARM datapath.
- Decodes the latched instruction and sequences the datapath through fetch, decode, execute, memory and writeback states.
- Holds the NZCV condition flags and gates every architectural write with the instruction's condition field.
- Drives every select and enable of the datapath; consumes Instr and ALUFlags from it.

Parameters:
None. Widths are fixed by the datapath interface.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- Instr  in  32  latched instruction; bits [31:12] used.
- ALUFlags  in  4  {N,Z,C,V} of the current ALU result.
- PCWrite  out  1  PC register enable.
- MemWrite  out  1  memory write strobe.
- RegWrite  out  1  register file write enable.
- IRWrite  out  1  instruction register enable.
- AdrSrc  out  1  memory address select: 0 = PC, 1 = Result.
- RegSrc  out  2  [0] = 1 forces RA1 = R15; [1] = 1 makes RA2 = Instr[15:12].
- ALUSrcA  out  2  bit0: 0 = A, 1 = PC; bit1 is always 0.
- ALUSrcB  out  2  00 = shifted reg, 01 = ExtImm, 10 = constant 4.
- ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult.
- ImmSrc  out  2  equals Instr[27:26].
- ALUControl  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR.

Behaviour:
Clocking and reset
- Single clock; reset is synchronous and active-high.
- Reset sets state = FETCH, flags = 0000, cond_q = 0.
- While reset is high, all write enables (PCWrite, MemWrite, RegWrite, IRWrite) are forced to 0.
- Reset asserted mid-instruction abandons that instruction; the next cycle after release is FETCH.

Decode fields
- op = Instr[27:26]; funct = Instr[25:20]; cmd = Instr[24:21]; S = Instr[20]; L = Instr[20]; Rd = Instr[15:12].
- RegSrc[0] = (op == 10). RegSrc[1] = (op == 01 && !L).
- Supported data-processing cmds:
  - ADD 0100 → ALU ADD; SUB 0010 → SUB; AND 0000 → AND; ORR 1100 → ORR.
  - CMP 1010 → SUB with no register write, flags always written.
  - Any other cmd is unsupported.

Condition logic
- Condition codes: EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL.
- cond 1111 → condition false.
- cond_q is captured at the end of DECODE from Instr[31:28] and the stored flags.
- All gated writes in later states use cond_q only, never live flags.

Flags
- Flags are updated at the end of EXECUTER/EXECUTEI only, when cond_q && (S || CMP).
- NZ always load from ALUFlags[3:2].
- CV load from ALUFlags[1:0] only for ADD/SUB/CMP; AND/ORR leave CV unchanged.

FSM (Moore outputs; unlisted outputs are 0, ALUControl = ADD)
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=01, ALUSrcB=10, ResultSrc=10, PCWrite=1 → DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10. Next state:
  - op=00, I=0 → EXECUTER.
  - op=00, I=1 → EXECUTEI.
  - op=00 with unsupported cmd → FETCH.
  - op=01 → MEMADR.
  - op=10 → BRANCH.
  - op=11 → FETCH, with no side effects.
- EXECUTER: ALUSrcA=00, ALUSrcB=00, ALUControl=decoded → ALUWB, or FETCH if CMP.
- EXECUTEI: as EXECUTER but ALUSrcB=01.
- ALUWB: ResultSrc=00; RegWrite = cond_q; PCWrite = cond_q && Rd==15 → FETCH.
- MEMADR: ALUSrcA=00, ALUSrcB=01, ADD → MEMREAD if L, else MEMWRITE.
- MEMREAD: AdrSrc=1, ResultSrc=00 → MEMWB.
- MEMWB: ResultSrc=01; RegWrite = cond_q; PCWrite = cond_q && Rd==15 → FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite = cond_q → FETCH.
- BRANCH: ALUSrcA=00, ALUSrcB=01, ResultSrc=10, PCWrite = cond_q → FETCH.

Latency (cycles per instruction)
- Branch: 3.
- Data-processing: 4.
- CMP: 3.
- STR: 4.
- LDR: 5.
- Unsupported: 2.

Decomposition:
- Package mc_ctrl_pkg holds:
  - state_t enum (FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH).
  - ALU op, cmd, cond and select-encoding localparams.
- Sub-module mc_main_fsm: state register and Moore output decode.
- Top level keeps the instruction decoder, flags register, cond_q flop and condition evaluator.

Test Plan:
1. Reset held 2 cycles, then released:
   - FETCH outputs appear with IRWrite=1, PCWrite=1.
   - flags=0000.
   - No write enables are asserted while reset is high.
2. ADDS R1,R2,#5 (E2921005) with ALUFlags=0000:
   - States FETCH, DECODE, EXECUTEI, ALUWB.
   - ALUSrcB=01 in EXECUTEI; RegWrite=1 in ALUWB.
   - Flags=0000.
3. CMP R1,R1 with ALUFlags=0110, then BEQ (0A000002):
   - BRANCH asserts PCWrite=1.
   - Repeat the BEQ with ALUFlags=0000 at CMP → PCWrite=0 in BRANCH.
4. LDR R3,[R0,#8] (E5903008):
   - 5 cycles total.
   - MEMREAD AdrSrc=1; MEMWB ResultSrc=01, RegWrite=1.
5. STR R3,[R0] with cond NE and Z=1:
   - RegSrc=10.
   - MEMWRITE has AdrSrc=1, MemWrite=0.
6. Reset asserted during MEMADR:
   - Next state is FETCH.
   - No MemWrite or RegWrite pulse occurs.
